// File: rtl/pipe_ctrl.sv
// pipe_ctrl: run/launch/drain sequencer and load-use/branch/jump hazard control for a 5-stage pipeline.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall and flush event counters.
`default_nettype none

module pipe_ctrl #(
    parameter int PC_W         = 8,
    parameter int REG_W        = 5,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             start,
    input  logic [PC_W-1:0]  halt_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_jump,
    input  logic             ex_branch_taken,
    output logic             run,
    output logic             pc_clr,
    output logic             stall,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int D_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t         state;
    logic [D_W-1:0] drain_cnt;
    logic           load_use;
    logic           halt_hit;
    logic           launch_req;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use   = ex_memread && (ex_rt != '0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign halt_hit   = (pc == halt_addr) && !ex_branch_taken && !load_use;
    assign launch_req = start && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        stall      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        case (state)
            S_LAUNCH: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end
            S_RUN: begin
                if (ex_branch_taken) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (load_use) begin
                    stall      = 1'b1;
                    flush_idex = 1'b1;
                end else if (id_jump) begin
                    flush_ifid = 1'b1;
                end
            end
            S_DRAIN: flush_ifid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state     <= S_IDLE;
            run       <= 1'b0;
            pc_clr    <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LAUNCH;
                        pc_clr    <= 1'b1;
                        done      <= 1'b0;
                        cycle_cnt <= '0;
                    end
                end
                S_LAUNCH: begin
                    state  <= S_RUN;
                    pc_clr <= 1'b0;
                    run    <= 1'b1;
                end
                S_RUN: begin
                    if (cycle_cnt != '1)
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (halt_hit) begin
                        state     <= S_DRAIN;
                        run       <= 1'b0;
                        drain_cnt <= D_W'(DRAIN_CYCLES - 1);
                    end
                end
                S_DRAIN: begin
                    if (cycle_cnt != '1)
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (drain_cnt == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - D_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    run    <= 1'b0;
                    pc_clr <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // In RUN, flush_ifid is high exactly for a branch or an unblocked jump.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (launch_req) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (state == S_RUN) begin
            if (stall && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (flush_ifid && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table vectors, directed corner sequences and random stimulus against a behavioural model.
`default_nettype none

module tb_pipe_ctrl;

    localparam int PC_W  = 8;
    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam int DRAIN = 4;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_RUN    = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_DONE   = 4;

    logic             Clk;
    logic             Clr;
    logic             start;
    logic [PC_W-1:0]  halt_addr;
    logic [PC_W-1:0]  pc;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt;
    logic             id_jump;
    logic             ex_branch_taken;
    logic             run;
    logic             pc_clr;
    logic             stall;
    logic             flush_ifid;
    logic             flush_idex;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_ctrl #(
        .PC_W(PC_W), .REG_W(REG_W), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .Clk(Clk), .Clr(Clr), .start(start), .halt_addr(halt_addr), .pc(pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .run(run), .pc_clr(pc_clr),
        .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .done(done), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase, remaining drain bubbles, event totals.
    int ph;
    int drain_left;
    int mc, ms, mf;
    logic e_run, e_pcclr, e_stall, e_fi, e_fe, e_done;

    typedef struct packed {
        logic             memread;
        logic [REG_W-1:0] xrt;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rt;
        logic             jump;
        logic             br;
        logic             x_stall;
        logic             x_fi;
        logic             x_fe;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        ph = P_IDLE; drain_left = 0; mc = 0; ms = 0; mf = 0;
    endtask

    task automatic idle_inputs();
        start = 0; ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
        id_uses_rt = 0; id_jump = 0; ex_branch_taken = 0;
    endtask

    // Called just after a falling edge with inputs driven; checks, advances model, waits one cycle.
    task automatic step();
        logic dep;
        logic flush_ev;
        #1;
        dep = 1'b0;
        if (ex_memread && ex_rt != 0) begin
            if (ex_rt == id_rs) dep = 1'b1;
            if (id_uses_rt && ex_rt == id_rt) dep = 1'b1;
        end
        e_run   = (ph == P_RUN);
        e_pcclr = (ph == P_LAUNCH);
        e_done  = (ph == P_DONE);
        e_stall = e_run && !ex_branch_taken && dep;
        e_fi    = (ph == P_LAUNCH) || (ph == P_DRAIN) ||
                  (e_run && (ex_branch_taken || (id_jump && !dep)));
        e_fe    = (ph == P_LAUNCH) || (e_run && (ex_branch_taken || dep));
        flush_ev = e_run && (ex_branch_taken || (id_jump && !dep));
        chk("run", run, e_run);
        chk("pc_clr", pc_clr, e_pcclr);
        chk("done", done, e_done);
        chk("stall", stall, e_stall);
        chk("flush_ifid", flush_ifid, e_fi);
        chk("flush_idex", flush_idex, e_fe);
        chk("cycle_cnt", cycle_cnt, mc);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, ms);
        chk("flush_cnt", flush_cnt, mf);
`else
        chk("stall_cnt", stall_cnt, 0);
        chk("flush_cnt", flush_cnt, 0);
`endif
        case (ph)
            P_IDLE, P_DONE: if (start) begin
                ph = P_LAUNCH; mc = 0; ms = 0; mf = 0;
            end
            P_LAUNCH: ph = P_RUN;
            P_RUN: begin
                mc = sat_inc(mc);
                if (e_stall) ms = sat_inc(ms);
                if (flush_ev) mf = sat_inc(mf);
                if (pc == halt_addr && !ex_branch_taken && !dep) begin
                    ph = P_DRAIN; drain_left = DRAIN;
                end
            end
            P_DRAIN: begin
                mc = sat_inc(mc);
                drain_left--;
                if (drain_left == 0) ph = P_DONE;
            end
            default: ph = P_IDLE;
        endcase
        @(negedge Clk);
    endtask

    // Launch from IDLE/DONE and let pc ramp from 0 until done or the cycle budget runs out.
    task automatic ramp_run(input logic [PC_W-1:0] h, output int nrun, output int npcclr,
                            output int ndrain);
        logic [PC_W-1:0] pc_tb;
        logic seen_run;
        pc_tb = 0; nrun = 0; npcclr = 0; ndrain = 0; seen_run = 0;
        halt_addr = h;
        start = 1;
        for (int i = 0; i < 80; i++) begin
            pc = pc_tb;
            step();
            start = 0;
            if (e_pcclr) begin npcclr++; pc_tb = 0; end
            if (e_run) begin nrun++; seen_run = 1; pc_tb = pc_tb + 1'b1; end
            if (seen_run && !e_run && e_fi) ndrain++;
            if (ph == P_DONE) break;
        end
    endtask

    initial begin
        int nrun, npcclr, ndrain;
        vecs[0] = '{1, 8, 8, 0, 0, 0, 0, 1, 0, 1};
        vecs[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{1, 8, 3, 8, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 8, 3, 8, 1, 0, 0, 1, 0, 1};
        vecs[4] = '{1, 8, 8, 0, 0, 0, 1, 0, 1, 1};
        vecs[5] = '{1, 9, 9, 0, 0, 1, 0, 1, 0, 1};
        vecs[6] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[8] = '{0, 8, 8, 0, 0, 0, 0, 0, 0, 0};
        vecs[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1};

        idle_inputs();
        halt_addr = 8'h13;
        pc = 0;
        Clr = 1;
        #2;
        chk("rst_run", run, 0);
        chk("rst_done", done, 0);
        chk("rst_pc_clr", pc_clr, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        @(negedge Clk);
        @(negedge Clk);
        Clr = 0;
        model_reset();

        // Launch and run to halt at 0x13.
        step();
        ramp_run(8'h13, nrun, npcclr, ndrain);
        #1;
        chk("t1_pcclr_cycles", npcclr, 1);
        chk("t1_run_cycles", nrun, 20);
        chk("t1_drain_cycles", ndrain, 4);
        chk("t1_done", done, 1);
        chk("t1_cycle_cnt", cycle_cnt, 24);

        // Hazard table inside a long run.
        halt_addr = 8'hFF;
        pc = 8'h40;
        start = 1;
        step();
        start = 0;
        step();
        for (int i = 0; i < 10; i++) begin
            ex_memread = vecs[i].memread; ex_rt = vecs[i].xrt;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
            id_jump = vecs[i].jump; ex_branch_taken = vecs[i].br;
            #1;
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].x_stall);
            chk($sformatf("vec%0d_flush_ifid", i), flush_ifid, vecs[i].x_fi);
            chk($sformatf("vec%0d_flush_idex", i), flush_idex, vecs[i].x_fe);
            step();
        end
        idle_inputs();
        #1;
`ifdef PIPE_PERF_CNT_EN
        chk("tbl_stall_cnt", stall_cnt, 3);
        chk("tbl_flush_cnt", flush_cnt, 3);
`else
        chk("tbl_stall_cnt", stall_cnt, 0);
        chk("tbl_flush_cnt", flush_cnt, 0);
`endif
        chk("tbl_cycle_cnt", cycle_cnt, 10);

        // Branch squashes the halt fetch; a later clean fetch drains.
        halt_addr = 8'h40;
        ex_branch_taken = 1;
        step();
        ex_branch_taken = 0;
        #1;
        chk("brhalt_stay_run", run, 1);
        step();
        #1;
        chk("brhalt_drain_run", run, 0);
        chk("brhalt_drain_fi", flush_ifid, 1);

        // Clear in the middle of DRAIN.
        step();
        step();
        Clr = 1;
        #1;
        chk("clr_run", run, 0);
        chk("clr_done", done, 0);
        chk("clr_cycle_cnt", cycle_cnt, 0);
        chk("clr_flush_ifid", flush_ifid, 0);
        chk("clr_stall_cnt", stall_cnt, 0);
        chk("clr_flush_cnt", flush_cnt, 0);
        model_reset();
        @(negedge Clk);
        Clr = 0;
        step();

        // Full run then restart from DONE.
        ramp_run(8'h03, nrun, npcclr, ndrain);
        #1;
        chk("t4_done", done, 1);
        chk("t4_cycle_cnt", cycle_cnt, 8);
        start = 1;
        step();
        start = 0;
        #1;
        chk("restart_done_clear", done, 0);
        chk("restart_cycle_cnt", cycle_cnt, 0);
        chk("restart_pc_clr", pc_clr, 1);

        // Random traffic.
        halt_addr = 8'h05;
        for (int i = 0; i < 800; i++) begin
            start           = ($urandom_range(0, 7) == 0);
            ex_memread      = $urandom_range(0, 1);
            ex_rt           = REG_W'($urandom_range(0, 3));
            id_rs           = REG_W'($urandom_range(0, 3));
            id_rt           = REG_W'($urandom_range(0, 3));
            id_uses_rt      = $urandom_range(0, 1);
            id_jump         = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            pc              = PC_W'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencing/hazard controller for the 5-stage MIPS pipeline; drives the fetch-stage PC register and the IF/ID, ID/EX pipeline registers.
- Runs a program from address 0 after `start`, detects load-use hazards, issues stall/flush for taken branches and jumps, detects the halt address, drains the pipeline, then flags completion.
- Sits between the PC/fetch stage, the ID-stage decoder and the EX-stage branch resolution; replaces ad-hoc over/crash/sortover wiring.

Parameters:
- PC_W, 8, width of PC and halt address
- REG_W, 5, register-specifier width
- CNT_W, 16, width of cycle/performance counters
- DRAIN_CYCLES, 4, bubble cycles after halt fetch before done (pipeline depth minus 1)

Ports:
- Clk  in  1  system clock, rising edge
- Clr  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; launches a run from IDLE or DONE
- halt_addr  in  PC_W  address of last program instruction
- pc  in  PC_W  current PC from fetch stage
- id_rs  in  REG_W  rs of instruction in ID
- id_rt  in  REG_W  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_memread  in  1  EX instruction is a load
- ex_rt  in  REG_W  destination of load in EX
- id_jump  in  1  ID instruction is a jump
- ex_branch_taken  in  1  EX resolved a taken branch
- run  out  1  PC may update (advance/redirect); 0 holds PC at 0 / halt
- pc_clr  out  1  one-cycle synchronous PC clear at run launch
- stall  out  1  hold PC and IF/ID this cycle
- flush_ifid  out  1  zero IF/ID on next edge
- flush_idex  out  1  zero ID/EX on next edge
- done  out  1  program finished, pipeline drained
- cycle_cnt  out  CNT_W  cycles spent in RUN+DRAIN
- stall_cnt  out  CNT_W  load-use stall cycles (see Optional Feature)
- flush_cnt  out  CNT_W  branch+jump flush events (see Optional Feature)

Behaviour:
- Reset (Clr=1, async):
  - state=IDLE.
  - run=0, pc_clr=0, done=0, all counters=0.
  - stall, flush_ifid and flush_idex read 0.
- States: IDLE, LAUNCH, RUN, DRAIN, DONE. Registered state; hazard outputs are combinational from inputs and state.
- IDLE:
  - run=0.
  - start -> LAUNCH.
- LAUNCH (1 cycle):
  - pc_clr=1, flush_ifid=1, flush_idex=1, run=0.
  - Counters zeroed.
  - done cleared.
  - Next state is RUN.
- RUN:
  - run=1; cycle_cnt increments every cycle (saturating at all-ones).
  - Priority 1, branch: ex_branch_taken -> flush_ifid=1, flush_idex=1, stall=0.
  - Priority 2, load-use: ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)) -> stall=1, flush_idex=1.
  - Priority 3, jump: id_jump && !stall -> flush_ifid=1.
  - Branch and load-use together: branch wins (the dependent ID instruction is squashed anyway).
  - Jump and load-use together: stall wins; the jump re-presents next cycle.
  - When pc==halt_addr, with no stall and no branch this cycle -> DRAIN, drain counter=DRAIN_CYCLES-1.
  - If branch_taken coincides with pc==halt_addr, stay in RUN (the halt fetch is squashed).
- DRAIN:
  - run=0 (PC frozen); flush_ifid=1 every cycle so bubbles enter.
  - stall=0; ex_branch_taken and id_jump are ignored.
  - cycle_cnt keeps counting; drain counter decrements.
  - At 0 -> DONE.
- DONE:
  - done=1 (held), run=0, counters frozen.
  - start -> LAUNCH.
- start while in LAUNCH/RUN/DRAIN is ignored.
- Clr mid-run aborts immediately to IDLE with all outputs at reset values.
- Register 0 never causes a stall.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt +1 per RUN cycle with stall=1.
  - flush_cnt +1 per RUN cycle with a branch flush or jump flush (max +1 per cycle).
  - Both counters saturate at all-ones, zero in LAUNCH, and freeze in DONE.
- Undefined: stall_cnt and flush_cnt are tied to 0; no counter registers are generated.

Test Plan:
- Launch and run:
  - Stimulus: Clr pulse, start at cycle 2, halt_addr=0x13, inputs idle, pc ramps from 0.
  - Required: LAUNCH with pc_clr=1 for exactly 1 cycle; run=1 from the next cycle.
  - Required: DRAIN entered when pc=0x13, with 4 cycles of run=0 and flush_ifid=1.
  - Required: done=1; cycle_cnt=20+4=24.
- Load-use:
  - Stimulus: ex_memread=1, ex_rt=8, id_rs=8 for one cycle.
  - Required: stall=1 and flush_idex=1 that cycle; stall_cnt=1 with PIPE_PERF_CNT_EN defined.
  - Repeat with ex_rt=0 -> stall=0.
- Branch beats load-use:
  - Stimulus: ex_branch_taken=1 with a matching load-use in the same cycle.
  - Required: stall=0, flush_ifid=1, flush_idex=1; flush_cnt +1.
- Jump blocked by stall:
  - Stimulus: id_jump=1 with a load-use hazard.
  - Required: stall=1, flush_ifid=0.
  - Next cycle (hazard gone): flush_ifid=1.
- Branch at halt address:
  - Stimulus: pc=halt_addr with ex_branch_taken=1.
  - Required: stays in RUN; DRAIN only entered on a later non-squashed fetch of halt_addr.
- Reset mid-DRAIN and restart:
  - Stimulus: Clr asserted during DRAIN.
  - Required: run=0, done=0, counters=0 asynchronously.
  - Then: start in DONE after a full run -> done clears in LAUNCH and cycle_cnt restarts from 0.
